// File: rtl/key_event_reporter.sv
// Debounces NUM_KEYS buttons, counts press events and reports each one as a
// 3-byte 8N1 UART record {'K', mask, count}, queued through a small FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a queued event
// START | start bit (0) for one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1); then next byte of the record or back to IDLE
module key_event_reporter #(
   parameter int NUM_KEYS        = 2,
   parameter int CNT_WIDTH       = 2,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int CLKS_PER_BIT    = 234,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_KEYS-1:0]  key_in,
   output logic [NUM_KEYS-1:0]  key_state,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 uart_tx,
   output logic                 tx_busy,
   output logic                 overflow
);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW  = $clog2(CLKS_PER_BIT + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int RW  = NUM_KEYS + CNT_WIDTH;
   localparam logic [DBW-1:0] DB_RELOAD  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]  BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]    FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [NUM_KEYS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, level;
   logic [NUM_KEYS-1:0]  key_state_q, key_state_d, key_prev_q, key_prev_d, rise;
   logic [DBW-1:0]       db_cnt_q [NUM_KEYS];
   logic [DBW-1:0]       db_cnt_d [NUM_KEYS];
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 evt, push, pop, fifo_empty, fifo_full;
   logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
   logic [RW-1:0]        fifo_mem_q [FIFO_DEPTH];
   logic [RW-1:0]        head;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [7:0]           shift_q, shift_d;
   logic [RW-1:0]        rec_q, rec_d;
   logic                 uart_tx_q, uart_tx_d;
   logic [7:0]           mask8, cnt8, next_byte;

   // Input conditioning and per-key debounce (down-counter reloads while stable)
   always_comb begin
      sync1_d     = key_in;
      sync2_d     = sync1_q;
      level       = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
      key_state_d = key_state_q;
      key_prev_d  = key_state_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         db_cnt_d[i] = DB_RELOAD;
         if (level[i] != key_state_q[i]) begin
            if (db_cnt_q[i] == '0)
               key_state_d[i] = level[i];
            else
               db_cnt_d[i] = db_cnt_q[i] - DBW'(1);
         end
      end
   end

   // Press events, counter and FIFO bookkeeping
   always_comb begin
      rise       = key_state_q & ~key_prev_q;
      evt        = |rise;
      count_d    = evt ? count_q + CNT_WIDTH'(1) : count_q;
      fill       = wr_ptr_q - rd_ptr_q;
      fifo_empty = (fill == '0);
      fifo_full  = (fill == FIFO_FULL);
      pop        = (state_q == S_IDLE) && !fifo_empty;
      push       = evt && (!fifo_full || pop);
      overflow_d = overflow_q | (evt & ~push);
      wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
   end

   assign head = fifo_mem_q[rd_ptr_q[AW-1:0]];

   // UART transmitter
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      rec_d      = rec_q;
      mask8      = '0;
      mask8[NUM_KEYS-1:0]  = rec_q[RW-1:CNT_WIDTH];
      cnt8       = '0;
      cnt8[CNT_WIDTH-1:0]  = rec_q[CNT_WIDTH-1:0];
      next_byte  = (byte_idx_q == 2'd0) ? mask8 : cnt8;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               rec_d      = head;
               byte_idx_d = 2'd0;
               shift_d    = 8'h4B;
               timer_d    = BIT_RELOAD;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (timer_q == '0) begin
               timer_d   = BIT_RELOAD;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_DATA: begin
            if (timer_q == '0) begin
               timer_d = BIT_RELOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_STOP: begin
            if (timer_q == '0) begin
               if (byte_idx_q < 2'd2) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  shift_d    = next_byte;
                  timer_d    = BIT_RELOAD;
                  state_d    = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Line level is registered from the next state so the pin never glitches
      case (state_d)
         S_START: uart_tx_d = 1'b0;
         S_DATA:  uart_tx_d = shift_d[0];
         default: uart_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         key_state_q <= '0;
         key_prev_q  <= '0;
         for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= DB_RELOAD;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         byte_idx_q  <= '0;
         shift_q     <= '0;
         rec_q       <= '0;
         uart_tx_q   <= 1'b1;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         key_state_q <= key_state_d;
         key_prev_q  <= key_prev_d;
         for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         shift_q     <= shift_d;
         rec_q       <= rec_d;
         uart_tx_q   <= uart_tx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {rise, count_d};
   end

   assign key_state = key_state_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign uart_tx   = uart_tx_q;
   assign tx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_event_reporter.sv
// Self-checking bench for key_event_reporter: UART decoder plus an event-scheduling
// reference model (record start times, FIFO capacity, wrapping count).
module tb_key_event_reporter;
   localparam int NK  = 2;
   localparam int CW  = 2;
   localparam int DB  = 8;
   localparam int CPB = 4;
   localparam int FD  = 2;
   localparam int REC_CYCLES = 30 * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_in = '0;
   logic [NK-1:0] key_state;
   logic [CW-1:0] count;
   logic          uart_tx, tx_busy, overflow;

   key_event_reporter #(
      .NUM_KEYS(NK), .CNT_WIDTH(CW), .KEY_ACTIVE_LOW(1'b0),
      .DEBOUNCE_CYCLES(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_state(key_state),
      .count(count), .uart_tx(uart_tx), .tx_busy(tx_busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // UART receive monitor: samples mid-bit on the falling clock edge
   bit mon_en = 1'b0;
   int rx_q[$];
   int run_q[$];
   int low_cycles = 0;
   initial begin
      int t = 0;
      bit in_frame = 1'b0;
      logic [7:0] sh = '0;
      int run = 0;
      int k;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            in_frame = 1'b0;
            run = 0;
         end else begin
            if (uart_tx == 1'b0) low_cycles++;
            if (tx_busy) run++;
            else if (run > 0) begin
               run_q.push_back(run);
               run = 0;
            end
            if (!in_frame) begin
               if (uart_tx == 1'b0) begin
                  in_frame = 1'b1;
                  t = 0;
               end
            end else begin
               t++;
               if (t == CPB / 2) check("start_bit", uart_tx, 0);
               else if (t > CPB / 2 && ((t - CPB / 2) % CPB) == 0) begin
                  k = (t - CPB / 2) / CPB;
                  if (k <= 8) sh[k-1] = uart_tx;
                  else begin
                     check("stop_bit", uart_tx, 1);
                     rx_q.push_back(int'(sh));
                     in_frame = 1'b0;
                  end
               end
            end
         end
      end
   end

   // Reference model: which events fit, when each record starts, what it carries
   int m_count = 0;
   int m_ovf   = 0;
   int m_starts[$];
   int exp_bytes[$];
   int exp_nrec = 0;
   int rx_base  = 0;
   int run_base = 0;

   task automatic model_reset();
      m_count = 0;
      m_ovf   = 0;
      m_starts.delete();
      exp_bytes.delete();
      exp_nrec = 0;
   endtask

   // te is the clock edge on which the press is counted
   task automatic model_event(input int mask, input int te);
      int pend = 0;
      int s;
      m_count = (m_count + 1) % (1 << CW);
      foreach (m_starts[i]) if (m_starts[i] > te) pend++;
      if (pend < FD) begin
         s = te + 1;
         if (m_starts.size() > 0 && m_starts[$] + REC_CYCLES + 1 > s)
            s = m_starts[$] + REC_CYCLES + 1;
         m_starts.push_back(s);
         exp_bytes.push_back(8'h4B);
         exp_bytes.push_back(mask);
         exp_bytes.push_back(m_count);
         exp_nrec++;
      end else begin
         m_ovf = 1;
      end
   endtask

   task automatic drive_press(input logic [NK-1:0] mask);
      key_in = mask;
      model_event(int'(mask), cyc + 2 + DB + 1);
   endtask

   task automatic press(input logic [NK-1:0] mask, input int hold, input int low);
      @(posedge clk); #1;
      drive_press(mask);
      repeat (hold) @(posedge clk);
      #1 key_in = '0;
      repeat (low) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      key_in = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_quiet(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 20 && n < 3000) begin
         @(negedge clk);
         n++;
         if (tx_busy) quiet = 0;
         else quiet++;
      end
      check({tag, "_quiet"}, int'(quiet >= 20), 1);
   endtask

   task automatic compare_rx(input string tag);
      int nrx = rx_q.size() - rx_base;
      int nrun = run_q.size() - run_base;
      check({tag, "_nbytes"}, nrx, exp_bytes.size());
      for (int i = 0; i < nrx && i < exp_bytes.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), rx_q[rx_base+i], exp_bytes[i]);
      check({tag, "_nrec"}, nrun, exp_nrec);
      for (int i = 0; i < nrun; i++)
         check($sformatf("%s_busy%0d", tag, i), run_q[run_base+i], REC_CYCLES);
      rx_base  = rx_q.size();
      run_base = run_q.size();
      exp_bytes.delete();
      exp_nrec = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      logic [NK-1:0] ks_or;
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_key_state", key_state, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_tx_busy", tx_busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      mon_en = 1'b1;

      // Single press with debounce latency window
      @(posedge clk); #1;
      drive_press(2'b01);
      repeat (8) @(negedge clk);
      check("single_ks_early", key_state, 0);
      repeat (4) @(negedge clk);
      check("single_ks_late", key_state, 1);
      repeat (28) @(posedge clk);
      #1 key_in = '0;
      wait_quiet("single");
      check("single_count", count, m_count);
      compare_rx("single");

      // Bounce rejection
      do_reset();
      lows = low_cycles;
      ks_or = '0;
      for (int p = 0; p < 8; p++) begin
         int h = $urandom_range(3, 7);
         for (int c = 0; c < h + 2; c++) begin
            @(posedge clk); #1 key_in = (c < h) ? 2'b01 : 2'b00;
            @(negedge clk) ks_or |= key_state;
         end
      end
      for (int c = 0; c < 30; c++) @(negedge clk) ks_or |= key_state;
      check("bounce_key_state", ks_or, 0);
      check("bounce_count", count, 0);
      check("bounce_tx_low", low_cycles - lows, 0);
      compare_rx("bounce");

      // Counter wrap: five presses of key1
      do_reset();
      for (int p = 0; p < 5; p++) press(2'b10, 40, 160);
      wait_quiet("wrap");
      check("wrap_count", count, m_count);
      check("wrap_count_spec", count, 1);
      compare_rx("wrap");

      // Simultaneous press
      do_reset();
      press(2'b11, 30, 30);
      wait_quiet("simul");
      check("simul_count", count, 1);
      compare_rx("simul");

      // Overflow: four presses during the first record
      do_reset();
      for (int p = 0; p < 4; p++) press(2'b01, 10, 10);
      @(negedge clk);
      check("ovf_flag", overflow, m_ovf);
      check("ovf_flag_spec", overflow, 1);
      check("ovf_count", count, m_count);
      wait_quiet("ovf");
      check("ovf_sticky", overflow, 1);
      compare_rx("ovf");

      // Reset during byte 1 data bits
      do_reset();
      press(2'b01, 12, 16);
      repeat (34) @(posedge clk);
      #1;
      check("midrst_busy_before", tx_busy, 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      exp_bytes.push_back(8'h4B);
      @(negedge clk);
      check("midrst_uart_tx", uart_tx, 1);
      check("midrst_tx_busy", tx_busy, 0);
      check("midrst_count", count, 0);
      check("midrst_overflow", overflow, 0);
      lows = low_cycles;
      repeat (200) @(negedge clk);
      check("midrst_silent", low_cycles - lows, 0);
      compare_rx("midrst");

      // Randomized bursts of presses against the model
      do_reset();
      for (int b = 0; b < 6; b++) begin
         int nk = $urandom_range(1, 4);
         for (int i = 0; i < nk; i++)
            press(2'($urandom_range(1, 3)), $urandom_range(12, 14), $urandom_range(16, 18));
         wait_quiet($sformatf("rand%0d", b));
         check($sformatf("rand%0d_count", b), count, m_count);
         check($sformatf("rand%0d_ovf", b), overflow, m_ovf);
         compare_rx($sformatf("rand%0d", b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
